// File: rtl/axis_video_tpg.sv
`default_nettype none
// ============================================================================
// axis_video_tpg : AXI4-Stream video test pattern generator (solid/ramp/bars/checker)
// Optional macro AXIS_TPG_MOTION_EN animates ramp and colour bars per frame.
// Revision: 1.0
// ============================================================================
module axis_video_tpg #(
  parameter int C_s_DATA_WIDTH       = 8,
  parameter int C_m_AXIS_TDATA_WIDTH = 32,
  parameter int H_ACTIVE             = 640,
  parameter int V_ACTIVE             = 480
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_enable,
  input  logic [1:0]                      i_pattern,
  output logic [C_m_AXIS_TDATA_WIDTH-1:0] o_m_axis_video_tdata,
  output logic                            o_m_axis_video_tvalid,
  input  logic                            i_m_axis_video_tready,
  output logic                            o_m_axis_video_tlast,
  output logic                            o_m_axis_video_tuser,
  output logic                            o_frame_done
);

  localparam int W     = C_s_DATA_WIDTH;
  localparam int NCOMP = C_m_AXIS_TDATA_WIDTH / W;
  // Counters carry spare high bits so x[3] and y[3] exist for the smallest frames.
  localparam int XW    = $clog2(H_ACTIVE) + 2;
  localparam int YW    = $clog2(V_ACTIVE) + 4;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BCW   = $clog2(BAR_W) + 1;

  localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BAR_W - 1);
  localparam logic [W-1:0]   COMP_ONE = '1;
  localparam logic [W-1:0]   COMP_MID = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [XW-1:0]  x, x_nxt;
  logic [YW-1:0]  y, y_nxt;
  logic [BCW-1:0] bar_cnt, bar_cnt_nxt;
  logic [2:0]     bar, bar_nxt;
  logic [1:0]     pattern, pattern_nxt;
  logic           done_q, done_nxt;
  logic           at_eol, at_eof;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      bar_cnt <= '0;
      bar     <= '0;
      pattern <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      bar_cnt <= bar_cnt_nxt;
      bar     <= bar_nxt;
      pattern <= pattern_nxt;
      done_q  <= done_nxt;
    end
  end

  assign at_eol = (x == X_LAST);
  assign at_eof = at_eol && (y == Y_LAST);

  always_comb begin
    state_nxt   = state;
    x_nxt       = x;
    y_nxt       = y;
    bar_cnt_nxt = bar_cnt;
    bar_nxt     = bar;
    pattern_nxt = pattern;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_nxt   = ACTIVE;
          pattern_nxt = i_pattern;
          x_nxt       = '0;
          y_nxt       = '0;
          bar_cnt_nxt = '0;
          bar_nxt     = '0;
        end
      end
      ACTIVE: begin
        if (i_m_axis_video_tready) begin
          if (at_eol) begin
            x_nxt       = '0;
            bar_cnt_nxt = '0;
            bar_nxt     = '0;
            if (at_eof) begin
              y_nxt    = '0;
              done_nxt = 1'b1;
              // Back-to-back frames resample the pattern; otherwise drop to idle.
              if (i_enable) begin
                pattern_nxt = i_pattern;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              y_nxt = y + 1'b1;
            end
          end else begin
            x_nxt = x + 1'b1;
            if (bar_cnt == BC_LAST) begin
              bar_cnt_nxt = '0;
              bar_nxt     = bar + 1'b1;
            end else begin
              bar_cnt_nxt = bar_cnt + 1'b1;
            end
          end
        end
      end
    endcase
  end

  logic [W-1:0] ramp_off;
  logic [2:0]   bar_off;

`ifdef AXIS_TPG_MOTION_EN
  logic [7:0] frame_cnt;

  // Advances on the edge that raises frame_done so the next frame already sees the new count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt <= '0;
    end else if (done_nxt) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign ramp_off = W'(frame_cnt);
  assign bar_off  = frame_cnt[2:0];
`else
  assign ramp_off = '0;
  assign bar_off  = '0;
`endif

  logic [W-1:0] comp_r, comp_g, comp_b, ramp;
  logic [2:0]   bar_idx;

  always_comb begin
    comp_r  = '0;
    comp_g  = '0;
    comp_b  = '0;
    ramp    = W'(x) + ramp_off;
    bar_idx = bar + bar_off;
    case (pattern)
      2'd0: begin
        comp_r = COMP_MID;
        comp_g = COMP_MID;
        comp_b = COMP_MID;
      end
      2'd1: begin
        comp_r = ramp;
        comp_g = ramp;
        comp_b = ramp;
      end
      2'd2: begin
        // Bar order white..black maps onto the inverted bits of the index.
        comp_r = bar_idx[1] ? '0 : COMP_ONE;
        comp_g = bar_idx[2] ? '0 : COMP_ONE;
        comp_b = bar_idx[0] ? '0 : COMP_ONE;
      end
      default: begin
        if (x[3] ^ y[3]) begin
          comp_r = COMP_ONE;
          comp_g = COMP_ONE;
          comp_b = COMP_ONE;
        end
      end
    endcase
  end

  logic [C_m_AXIS_TDATA_WIDTH-1:0] pixel;

  for (genvar k = 0; k < NCOMP; k++) begin : g_comp
    if (k == 0) begin : g_red
      assign pixel[k*W +: W] = comp_r;
    end else if (k == 1) begin : g_green
      assign pixel[k*W +: W] = comp_g;
    end else if (k == 2) begin : g_blue
      assign pixel[k*W +: W] = comp_b;
    end else begin : g_zero
      assign pixel[k*W +: W] = '0;
    end
  end

  logic active;
  assign active = (state == ACTIVE);

  assign o_m_axis_video_tvalid = active;
  assign o_m_axis_video_tdata  = active ? pixel : '0;
  assign o_m_axis_video_tlast  = active && at_eol;
  assign o_m_axis_video_tuser  = active && (x == '0) && (y == '0);
  assign o_frame_done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_video_tpg.sv
`default_nettype none
// ============================================================================
// tb_axis_video_tpg : scoreboard bench for axis_video_tpg with a frame-level model.
// Revision: 1.0
// ============================================================================
module tb_axis_video_tpg;

  localparam int W       = 8;
  localparam int DW      = 32;
  localparam int H       = 16;
  localparam int V       = 12;
  localparam int FR      = H * V;
  localparam int TIMEOUT = 20000;
`ifdef AXIS_TPG_MOTION_EN
  localparam int MOT = 1;
`else
  localparam int MOT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          tready = 1'b0;
  logic [1:0]    pattern = 2'd0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tuser, frame_done;

  axis_video_tpg #(
    .C_s_DATA_WIDTH(W), .C_m_AXIS_TDATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_pattern(pattern),
    .o_m_axis_video_tdata(tdata), .o_m_axis_video_tvalid(tvalid),
    .i_m_axis_video_tready(tready), .o_m_axis_video_tlast(tlast),
    .o_m_axis_video_tuser(tuser), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    logic          fin;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   total  = 0;
  int   fc     = 0;
  bit   rand_ready = 1'b0;
  int   bar_rgb[8] = '{7, 6, 3, 2, 5, 4, 1, 0};  // {R,G,B}: white..black

  function automatic logic [DW-1:0] exp_pix(input int x, input int y, input int p, input int f);
    int full = (1 << W) - 1;
    int r, g, b, c;
    logic [DW-1:0] d;
    case (p)
      0: begin r = 1 << (W - 1); g = r; b = r; end
      1: begin c = (x + MOT * (f % 256)) % (1 << W); r = c; g = c; b = c; end
      2: begin
        c = bar_rgb[(x / (H / 8) + MOT * (f % 8)) % 8];
        r = (c & 4) != 0 ? full : 0;
        g = (c & 2) != 0 ? full : 0;
        b = (c & 1) != 0 ? full : 0;
      end
      default: begin c = (((x / 8) % 2) != ((y / 8) % 2)) ? full : 0; r = c; g = c; b = c; end
    endcase
    d = '0;
    d[0 +: W]   = W'(r);
    d[W +: W]   = W'(g);
    d[2*W +: W] = W'(b);
    return d;
  endfunction

  task automatic push_frame(input int p);
    exp_t e;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        e.data = exp_pix(xx, yy, p, fc);
        e.last = (xx == H - 1);
        e.user = (xx == 0 && yy == 0);
        e.fin  = (xx == H - 1 && yy == V - 1);
        q.push_back(e);
      end
    end
    fc++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks protocol rules.
  bit            rst_prev = 1'b0;
  bit            done_exp = 1'b0;
  bit            gap_chk  = 1'b0;
  bit            hold     = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last, hold_user;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (rst_prev) begin
        checks++;
        if (tvalid || tdata != '0 || tlast || tuser || frame_done) begin
          errors++;
          $display("FAIL reset_outputs: got valid=%0b data=%h last=%0b user=%0b done=%0b, required all 0",
                   tvalid, tdata, tlast, tuser, frame_done);
        end
      end
      rst_prev = 1'b1;
      done_exp = 1'b0;
      gap_chk  = 1'b0;
      hold     = 1'b0;
    end else begin
      rst_prev = 1'b0;
      checks++;
      if (frame_done !== done_exp) begin
        errors++;
        $display("FAIL frame_done: got %0b, required %0b (pixels=%0d)", frame_done, done_exp, total);
      end
      done_exp = 1'b0;
      if (gap_chk) begin
        checks++;
        if (tvalid !== (q.size() != 0)) begin
          errors++;
          $display("FAIL frame_gap: tvalid got %0b, required %0b", tvalid, q.size() != 0);
        end
        gap_chk = 1'b0;
      end
      if (hold) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== hold_data || tlast !== hold_last || tuser !== hold_user) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%h last=%0b user=%0b, required valid=1 data=%h last=%0b user=%0b",
                   tvalid, tdata, tlast, tuser, hold_data, hold_last, hold_user);
        end
        hold = 1'b0;
      end
      if (tvalid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got tvalid=1 data=%h, required no pixel", tdata);
        end else if (tready) begin
          e = q.pop_front();
          checks++;
          if (tdata !== e.data || tlast !== e.last || tuser !== e.user) begin
            errors++;
            $display("FAIL pixel %0d: got data=%h last=%0b user=%0b, required data=%h last=%0b user=%0b",
                     total, tdata, tlast, tuser, e.data, e.last, e.user);
          end
          total++;
          if (e.fin) begin
            done_exp = 1'b1;
            gap_chk  = 1'b1;
          end
        end else begin
          hold      = 1'b1;
          hold_data = tdata;
          hold_last = tlast;
          hold_user = tuser;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_total(input int target);
    int n = 0;
    while (total < target && n < TIMEOUT) begin
      step();
      n++;
    end
    if (total < target) begin
      checks++;
      errors++;
      $display("FAIL wait_pixels: got %0d pixels, required %0d", total, target);
    end
  endtask

  // Runs n frames; enable and pattern are disturbed mid-frame, the next frame is armed halfway.
  task automatic play(input int n, input int pat0, input bit rnd);
    int base = total;
    int p;
    pattern = 2'(pat0);
    push_frame(pat0);
    enable = 1'b1;
    for (int f = 0; f < n; f++) begin
      wait_total(base + f * FR + 1);
      pattern = 2'($urandom_range(0, 3));
      enable  = 1'b0;
      wait_total(base + f * FR + FR / 2);
      if (f < n - 1) begin
        p = rnd ? int'($urandom_range(0, 3)) : (pat0 + f + 1) % 4;
        pattern = 2'(p);
        enable  = 1'b1;
        push_frame(p);
      end
    end
    wait_total(base + n * FR);
    repeat (6) step();
  endtask

  initial begin
    int base;
    repeat (4) step();
    rst = 1'b0;
    step();

    rand_ready = 1'b0;
    play(1, 1, 1'b0);
    play(3, 0, 1'b0);
    rand_ready = 1'b1;
    play(4, 3, 1'b1);
    play(2, 2, 1'b1);

    rand_ready = 1'b0;
    base = total;
    pattern = 2'd3;
    push_frame(3);
    enable = 1'b1;
    wait_total(base + 2 * H + 5);
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    q.delete();
    fc  = 0;
    rst = 1'b0;
    play(2, 1, 1'b0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending pixels, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
